// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Groups every non-clock signal of the fetch sequencer.
//   Redirect:   redirect_valid / redirect_target (from execute)
//   Imem:       imem_req, imem_addr out; imem_ack, imem_rdata in
//   Decode:     if_valid, if_instr, if_pc out; if_ready in
//   Status:     pc (current fetch PC), state_dbg (FSM state for checkers)
//   fault:      present only when FETCH_MISALIGN_FAULT_EN is defined
//   Modports: master = the sequencer, slave = its environment.
interface fetch_sequencer_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [31:0] pc;
  logic [2:0]  state_dbg;
`ifdef FETCH_MISALIGN_FAULT_EN
  logic        fault;
`endif

  modport master (
    input  redirect_valid, redirect_target, imem_ack, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, pc, state_dbg
`ifdef FETCH_MISALIGN_FAULT_EN
    , output fault
`endif
  );

  modport slave (
    output redirect_valid, redirect_target, imem_ack, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, pc, state_dbg
`ifdef FETCH_MISALIGN_FAULT_EN
    , input fault
`endif
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the PC, drives the instruction-memory fetch handshake and holds
//   one fetched instruction for decode. Redirects arriving while a fetch
//   is outstanding are parked until the memory acks; the stale data is
//   dropped.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    fetch_sequencer_if.master (redirect, imem, decode, pc, state_dbg)
// Optional feature macro: FETCH_MISALIGN_FAULT_EN
//   defined:   misaligned redirect targets raise a sticky fault and halt
//   undefined: target[1:0] is forced to 2'b00
// Handshakes:
//   imem:   a request is imem_req=1 with imem_addr; it completes on the
//           cycle imem_ack=1. Until then req and addr are held constant.
//   decode: the buffer transfers when if_valid && if_ready on a rising edge.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3
`ifdef FETCH_MISALIGN_FAULT_EN
    , S_HALT = 3'd4
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        imem_req_q, imem_req_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
`ifdef FETCH_MISALIGN_FAULT_EN
  logic        fault_q, fault_d;
  logic        halt_pend_q, halt_pend_d;
`endif

  logic        misalign;
  logic        redir;
  logic [31:0] tgt;

  always_comb begin
`ifdef FETCH_MISALIGN_FAULT_EN
    misalign = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
    tgt      = bus.redirect_target;
`else
    misalign = 1'b0;
    tgt      = {bus.redirect_target[31:2], 2'b00};
`endif
    // A usable redirect; a misaligned one is never applied to the PC.
    redir = bus.redirect_valid && !misalign;

    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
`ifdef FETCH_MISALIGN_FAULT_EN
    fault_d     = fault_q;
    halt_pend_d = halt_pend_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redir) pc_d = tgt;
`ifdef FETCH_MISALIGN_FAULT_EN
        if (misalign) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
`endif
      end

      S_REQ: begin
        if (bus.imem_ack) begin
          // Redirect in the ack cycle: drop the data, refetch at target.
          if (redir) pc_d = tgt;
`ifdef FETCH_MISALIGN_FAULT_EN
          else if (misalign) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
`endif
          else begin
            if_instr_d = bus.imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        end else if (redir) begin
          pending_d = tgt;
          state_d   = S_DRAIN;
        end
`ifdef FETCH_MISALIGN_FAULT_EN
        else if (misalign) begin
          // Request must still complete before halting.
          fault_d     = 1'b1;
          halt_pend_d = 1'b1;
          state_d     = S_DRAIN;
        end
`endif
      end

      S_HOLD: begin
        // Redirect beats if_ready: the buffered instruction is wrong-path.
        if (redir) begin
          if_valid_d = 1'b0;
          pc_d       = tgt;
          state_d    = S_REQ;
        end
`ifdef FETCH_MISALIGN_FAULT_EN
        else if (misalign) begin
          if_valid_d = 1'b0;
          fault_d    = 1'b1;
          state_d    = S_HALT;
        end
`endif
        else if (bus.if_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end

      S_DRAIN: begin
        if (bus.imem_ack) begin
`ifdef FETCH_MISALIGN_FAULT_EN
          if (halt_pend_q || misalign) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else
`endif
          begin
            pc_d    = redir ? tgt : pending_q;
            state_d = S_REQ;
          end
        end else if (redir) begin
          pending_d = tgt;
        end
`ifdef FETCH_MISALIGN_FAULT_EN
        else if (misalign) begin
          fault_d     = 1'b1;
          halt_pend_d = 1'b1;
        end
`endif
      end

`ifdef FETCH_MISALIGN_FAULT_EN
      S_HALT: state_d = S_HALT;
`endif

      default: state_d = S_IDLE;
    endcase

    imem_req_d = (state_d == S_REQ) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pending_q  <= 32'h0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
`ifdef FETCH_MISALIGN_FAULT_EN
      fault_q     <= 1'b0;
      halt_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      imem_req_q <= imem_req_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
`ifdef FETCH_MISALIGN_FAULT_EN
      fault_q     <= fault_d;
      halt_pend_q <= halt_pend_d;
`endif
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.pc        = pc_q;
  assign bus.state_dbg = state_q;
`ifdef FETCH_MISALIGN_FAULT_EN
  assign bus.fault     = fault_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the single-issue RISC-V core.
- Owns the PC register and its next-PC selection: PC+4 on a completed fetch, the jump/branch target on a redirect.
- Presents fetched instructions to decode through a one-entry valid/ready buffer.
- Handles redirects that arrive while a fetch is outstanding by draining and discarding the stale response.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  taken jump or branch this cycle.
- redirect_target  in  32  new PC for the redirect.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals the PC of the outstanding request.
- imem_ack  in  1  memory accepts and completes the request; imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- if_valid  out  1  if_instr/if_pc hold a valid instruction for decode.
- if_instr  out  32  buffered instruction.
- if_pc  out  32  PC of the buffered instruction.
- if_ready  in  1  decode consumes the buffer when if_valid && if_ready.
- pc  out  32  current fetch PC.
- fault  out  1  misaligned-redirect fault; exists only with the optional feature.

Behaviour:
- Reset: an asynchronous assert of reset forces all of the following, mid-transaction included; any outstanding request is abandoned.
  - state=IDLE, pc=RESET_PC, pending=0.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0, fault=0.
- imem_addr = pc in IDLE/REQ/HOLD and DRAIN.
- Handshake rule: while imem_req=1 without imem_ack, imem_addr and imem_req must not change.
- States:
  - IDLE: imem_req=0. Next cycle -> REQ. A redirect in IDLE loads pc=target.
  - REQ: imem_req=1.
    - ack without redirect: if_instr=imem_rdata, if_pc=pc, if_valid=1, pc=pc+4 (mod 2^32), -> HOLD.
    - ack with redirect: discard rdata, pc=target, stay REQ; the new address is driven the next cycle.
    - redirect without ack: pending=target, -> DRAIN.
  - HOLD: imem_req=0, if_valid=1.
    - redirect: if_valid=0, pc=target, -> REQ. Redirect wins over if_ready; the buffer is flushed even if consumed that cycle.
    - else if_ready: if_valid=0, -> REQ.
  - DRAIN: imem_req=1, addr is the stale pc.
    - redirect without ack: pending=target (latest wins).
    - ack: discard rdata, pc = redirect_valid ? redirect_target : pending, -> REQ.
- Invariants:
  - if_valid=1 only in HOLD.
  - No request is issued while the buffer is full.
  - Peak throughput is one instruction per 2 cycles with a zero-wait memory.
- pc wraps 32'hFFFFFFFC -> 32'h00000000 with no flag.

Optional Feature:
- Macro: FETCH_MISALIGN_FAULT_EN.
- Defined:
  - A redirect with target[1:0]!=2'b00 is not applied; fault is set sticky and the block enters HALT.
  - HALT: imem_req=0 and if_valid=0; it is left only by reset.
  - If the redirect arrives in REQ/DRAIN with a request outstanding, the block holds imem_req until ack, discards the data, then enters HALT.
- Undefined:
  - The fault port and HALT state are absent.
  - target[1:0] is forced to 2'b00 before use.

Test Plan:
- Reset, imem_ack always 1, if_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; if_pc matches each address; if_valid one cycle in every two.
- Fetch at 0x8 with memory acking after 3 wait cycles -> imem_addr stays 0x8 and imem_req stays 1 for all 3 cycles; then if_instr=rdata and pc=0xC.
- if_valid=1 at if_pc=0x4 with if_ready=0 for 5 cycles -> no imem_req; if_instr stable; the next request goes to 0x8 after if_ready=1.
- Redirect to 0x100 in REQ with no ack, ack arriving 2 cycles later -> that data is discarded and if_valid stays 0; the next request addr=0x100. Repeat with a second redirect to 0x200 during DRAIN -> next addr=0x200.
- Redirect to 0x40 in the same cycle as ack in REQ -> rdata discarded; next addr=0x40. Redirect in HOLD with if_ready=1 -> buffer flushed.
- Assert reset mid-DRAIN -> imem_req=0, pc=RESET_PC immediately. With FETCH_MISALIGN_FAULT_EN defined, redirect to 0x102 -> fault=1 and no further requests.
